pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage ARM pipeline, sitting beside the execute stage.

---
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage ARM pipeline.
// It detects RAW hazards between ID sources and EXE/MEM destinations. It flushes
// wrong-path instructions on a taken branch. It freezes the whole pipeline while
// the SRAM data port is busy, with a watchdog on that wait. It also keeps
// saturating stall and flush performance counters.
// Optional feature macro: FORWARDING_EN. When it is defined, only load-use
// hazards stall; all other hazards are resolved by forwarding.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src1,
  input  logic             id_two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             hazard_stall,
  output logic             flush,
  output logic             freeze_all,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_MEMWAIT,
    S_ERROR
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze_raw;
  logic              raw_hazard;
  logic              src1_exe;
  logic              src2_exe;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign src1_exe = id_use_src1 & (id_src1 == exe_dest);
  assign src2_exe = id_two_src  & (id_src2 == exe_dest);

`ifdef FORWARDING_EN
  // MEM results are forwarded, so the MEM stage never causes a stall.
  logic unused_mem;
  assign unused_mem = ^{mem_dest, mem_wb_en};
  assign raw_hazard = exe_wb_en & exe_mem_r_en & (src1_exe | src2_exe);
`else
  logic src1_mem;
  logic src2_mem;
  assign src1_mem   = id_use_src1 & (id_src1 == mem_dest);
  assign src2_mem   = id_two_src  & (id_src2 == mem_dest);
  assign raw_hazard = (exe_wb_en & (src1_exe | src2_exe)) |
                      (mem_wb_en & (src1_mem | src2_mem));
`endif

  // Freeze request from the SRAM wait state machine, before priority gating.
  always_comb begin
    freeze_raw = 1'b0;
    unique case (state)
      S_RUN:     freeze_raw = mem_req & ~sram_ready;
      S_MEMWAIT: freeze_raw = ~sram_ready;
      S_ERROR:   freeze_raw = 1'b1;
      default:   freeze_raw = 1'b1;
    endcase
  end

  // Outputs act in the same cycle. Priority order is freeze, then flush, then
  // stall. Holding rst low forces every output to zero immediately.
  assign freeze_all   = rst & freeze_raw;
  assign flush        = rst & ~freeze_raw & branch_taken;
  assign hazard_stall = rst & ~freeze_raw & ~branch_taken & raw_hazard;

  // SRAM wait tracking with a watchdog. ERROR is left only through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      unique case (state)
        S_RUN: begin
          if (mem_req && !sram_ready) begin
            state    <= S_MEMWAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        S_MEMWAIT: begin
          if (sram_ready) begin
            state    <= S_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= S_ERROR;
            mem_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_ERROR: begin
          mem_err <= 1'b1;
        end
        default: begin
          state   <= S_ERROR;
          mem_err <= 1'b1;
        end
      endcase
    end
  end

  // Saturating performance counters for stall/freeze cycles and flush pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (hazard_stall || freeze_all) stall_cycles <= sat_inc(stall_cycles);
      if (flush)                      flush_count  <= sat_inc(flush_count);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl. The driver applies one vector per
// cycle and queues the expected outputs. The monitor compares them on the
// falling edge.
module tb_pipeline_hazard_ctrl;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  s1, s2, ed, md;
  logic        u1, two, ewb, eld, mwb, br, mreq, rdy;
  logic        hs, fl, fz, me;
  logic [31:0] sc, fc;

  typedef struct {
    string       name;
    logic        hs, fl, fz, me;
    logic [31:0] sc, fc;
  } exp_t;

  exp_t        q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_sc = 0;
  logic [31:0] exp_fc = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_src1(s1), .id_src2(s2), .id_use_src1(u1), .id_two_src(two),
    .exe_dest(ed), .exe_wb_en(ewb), .exe_mem_r_en(eld),
    .mem_dest(md), .mem_wb_en(mwb),
    .branch_taken(br), .mem_req(mreq), .sram_ready(rdy),
    .hazard_stall(hs), .flush(fl), .freeze_all(fz), .mem_err(me),
    .stall_cycles(sc), .flush_count(fc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0d, expected %0d", n, f, act, exp);
    end
  endtask

  // Monitor: pop one expectation per cycle, away from the active edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "hazard_stall", 32'(hs), 32'(e.hs));
      chk(e.name, "flush",        32'(fl), 32'(e.fl));
      chk(e.name, "freeze_all",   32'(fz), 32'(e.fz));
      chk(e.name, "mem_err",      32'(me), 32'(e.me));
      chk(e.name, "stall_cycles", sc, e.sc);
      chk(e.name, "flush_count",  fc, e.fc);
    end
  end

  task automatic idle();
    s1 = 0; s2 = 0; ed = 0; md = 0;
    u1 = 0; two = 0; ewb = 0; eld = 0; mwb = 0;
    br = 0; mreq = 0; rdy = 0;
  endtask

  // Queue the expectation for the inputs just applied, then move to the next cycle.
  task automatic cyc(input string n, input logic e_hs, input logic e_fl,
                     input logic e_fz, input logic e_me);
    exp_t e;
    e.name = n; e.hs = e_hs; e.fl = e_fl; e.fz = e_fz; e.me = e_me;
    e.sc = exp_sc; e.fc = exp_fc;
    q.push_back(e);
    if (rst && (e_hs || e_fz) && exp_sc != 32'hFFFF_FFFF) exp_sc++;
    if (rst && e_fl && exp_fc != 32'hFFFF_FFFF) exp_fc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string n);
    rst = 1'b0; idle();
    exp_sc = 0; exp_fc = 0;
    cyc(n, 0, 0, 0, 0);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; idle();
    // Outputs stay low under reset even when every request input is active.
    mreq = 1; br = 1; u1 = 1; s1 = 3; ed = 3; ewb = 1; eld = 1;
    @(posedge clk); #1;
    cyc("reset_outs", 0, 0, 0, 0);
    rst = 1'b1; idle();
    cyc("idle", 0, 0, 0, 0);

    // Load-use on src1: stalls in EXE, then again from MEM without forwarding.
    u1 = 1; s1 = 3; ed = 3; ewb = 1; eld = 1;
    cyc("ld_use_exe", 1, 0, 0, 0);
    idle(); u1 = 1; s1 = 3; md = 3; mwb = 1;
    cyc("ld_use_mem", !FWD, 0, 0, 0);
    idle(); u1 = 1; s1 = 3;
    cyc("ld_use_done", 0, 0, 0, 0);

    // ALU producer in EXE read as src2.
    idle(); two = 1; s2 = 5; ed = 5; ewb = 1;
    cyc("alu_src2", !FWD, 0, 0, 0);
    two = 0;
    cyc("alu_src2_unused", 0, 0, 0, 0);
    idle(); u1 = 0; s1 = 5; ed = 5; ewb = 1; eld = 1;
    cyc("src1_not_used", 0, 0, 0, 0);
    u1 = 1; ewb = 0;
    cyc("exe_no_wb", 0, 0, 0, 0);
    idle(); u1 = 1; s1 = 7; md = 7; mwb = 1;
    cyc("mem_dep", !FWD, 0, 0, 0);

    // Branch together with a load-use: flush wins over the stall.
    idle(); br = 1; u1 = 1; s1 = 3; ed = 3; ewb = 1; eld = 1;
    cyc("br_over_lduse", 0, 1, 0, 0);
    idle();
    cyc("post_br", 0, 0, 0, 0);

    // SRAM busy for 3 cycles, ready on the last allowed wait cycle.
    do_reset("reset2");
    mreq = 1; rdy = 0;
    cyc("wait1", 0, 0, 1, 0);
    cyc("wait2", 0, 0, 1, 0);
    cyc("wait3", 0, 0, 1, 0);
    rdy = 1;
    cyc("ready", 0, 0, 0, 0);
    idle();
    cyc("after_wait", 0, 0, 0, 0);
    mreq = 1; rdy = 1;
    cyc("single_access", 0, 0, 0, 0);

    // Branch and hazard held during a freeze: flush appears only after the thaw.
    idle(); mreq = 1; rdy = 0; br = 1;
    u1 = 1; s1 = 3; ed = 3; ewb = 1; eld = 1;
    cyc("br_frozen1", 0, 0, 1, 0);
    cyc("br_frozen2", 0, 0, 1, 0);
    rdy = 1;
    cyc("br_thaw", 0, 1, 0, 0);
    idle();
    cyc("post_thaw", 0, 0, 0, 0);

    // Watchdog: with MEM_TIMEOUT=4, four wait cycles lead to ERROR.
    do_reset("reset3");
    mreq = 1; rdy = 0;
    cyc("to_run", 0, 0, 1, 0);
    cyc("to_cnt1", 0, 0, 1, 0);
    cyc("to_cnt2", 0, 0, 1, 0);
    cyc("to_cnt3", 0, 0, 1, 0);
    cyc("error", 0, 0, 1, 1);
    mreq = 0; rdy = 1; br = 1;
    cyc("error_sticky", 0, 0, 1, 1);
    // Reset is asserted between clock edges and must act before the next edge.
    mreq = 1; rdy = 0; br = 1;
    rst = 1'b0; exp_sc = 0; exp_fc = 0;
    cyc("async_reset", 0, 0, 0, 0);
    rst = 1'b1; idle();
    cyc("run_after_reset", 0, 0, 0, 0);
    mreq = 1; rdy = 0;
    cyc("rerun_wait", 0, 0, 1, 0);
    rdy = 1;
    cyc("rerun_ready", 0, 0, 0, 0);
    idle();
    cyc("final", 0, 0, 0, 0);

    @(negedge clk); #1;
    chk("scoreboard", "pending", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
